// File: rtl/alu_share_arb_if.sv
// Bus bundle for alu_share_arb: two request channels, one response channel
// and the grant statistics. The master side is the clients plus the response
// consumer; the slave side is the arbiter itself.
interface alu_share_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err,
        input  grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err,
        output grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one 32-bit ALU between two
// clients, with a one-entry registered response stage tagged by client ID.
// Optional feature macro: ALU_ARB_STATS_EN enables saturating per-client
// grant counters; without it grant_cnt0/grant_cnt1 read as zero.
module alu_share_arb (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus_if
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_RSV = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // ALU slice: returns {err, ovf, result}. Overflow only for ADD/SUB;
    // the reserved opcode yields a zero result with the error flag set.
    function automatic logic [33:0] alu_eval(input logic [2:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] res;
        logic        ovf;
        logic        err;
        res = 32'h0000_0000;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_ADD: begin
                res = a + b;
                ovf = (a[31] == b[31]) && (res[31] != a[31]);
            end
            OP_SUB: begin
                res = a - b;
                // Subtraction adds ~b, so signs must differ to overflow.
                ovf = (a[31] != b[31]) && (res[31] != a[31]);
            end
            OP_SLT: res = {31'h0000_0000, ($signed(a) < $signed(b))};
            OP_RSV: err = 1'b1;
            default: err = 1'b1;
        endcase
        return {err, ovf, res};
    endfunction

    logic        rr_ptr_q, rr_ptr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_err_q, rsp_err_d;

    logic        slot_free_s;
    logic        grant0_s;
    logic        grant1_s;
    logic [2:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [33:0] alu_out_s;

    // Response slot can take a new result if empty or draining this cycle.
    assign slot_free_s = !rsp_valid_q || bus_if.rsp_ready;

    // Round-robin grant: a lone requester always wins; on contention the
    // pointer picks. Nothing is granted while the slot is occupied.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (slot_free_s) begin
            if (bus_if.req0_valid && bus_if.req1_valid) begin
                grant0_s = !rr_ptr_q;
                grant1_s = rr_ptr_q;
            end else begin
                grant0_s = bus_if.req0_valid;
                grant1_s = bus_if.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand mux feeding the single shared ALU.
    always_comb begin
        sel_op_s = bus_if.req0_op;
        sel_a_s  = bus_if.req0_a;
        sel_b_s  = bus_if.req0_b;
        if (grant1_s) begin
            sel_op_s = bus_if.req1_op;
            sel_a_s  = bus_if.req1_a;
            sel_b_s  = bus_if.req1_b;
        end else begin
            sel_op_s = bus_if.req0_op;
            sel_a_s  = bus_if.req0_a;
            sel_b_s  = bus_if.req0_b;
        end
    end

    assign alu_out_s = alu_eval(sel_op_s, sel_a_s, sel_b_s);

    // Next-state for the response stage and round-robin pointer.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        if (grant0_s || grant1_s) begin
            // Pointer moves to whichever client lost (or did not ask).
            rr_ptr_d     = grant0_s;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1_s;
            rsp_result_d = alu_out_s[31:0];
            rsp_zero_d   = (alu_out_s[31:0] == 32'h0000_0000);
            rsp_ovf_d    = alu_out_s[32];
            rsp_err_d    = alu_out_s[33];
        end else if (slot_free_s) begin
            rsp_valid_d  = 1'b0;
        end else begin
            rsp_valid_d  = rsp_valid_q;
        end
    end

    // Response and pointer registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'h0000_0000;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus_if.req0_ready = grant0_s;
    assign bus_if.req1_ready = grant1_s;
    assign bus_if.rsp_valid  = rsp_valid_q;
    assign bus_if.rsp_id     = rsp_id_q;
    assign bus_if.rsp_result = rsp_result_q;
    assign bus_if.rsp_zero   = rsp_zero_q;
    assign bus_if.rsp_ovf    = rsp_ovf_q;
    assign bus_if.rsp_err    = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Saturating grant counters, one per client.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (grant0_s && (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end else begin
            cnt0_d = cnt0_q;
        end
        if (grant1_s && (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end else begin
            cnt1_d = cnt1_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus_if.grant_cnt0 = cnt0_q;
    assign bus_if.grant_cnt1 = cnt1_q;
`else
    assign bus_if.grant_cnt0 = 16'h0000;
    assign bus_if.grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: reset checks, a table of single-op
// vectors, hand-written contention/back-pressure/reset sequences, and a
// randomized run compared against a behavioural model of the arbiter.
module tb_alu_share_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_share_arb_if bus ();

    alu_share_arb dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    // Model state
    bit          m_valid, m_id, m_zero, m_ovf, m_err, m_pref;
    logic [31:0] m_result;
    int          m_cnt0, m_cnt1;

    typedef struct {
        bit          cli;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          zero;
        bit          ovf;
        bit          err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output bit ovf, output bit err);
        longint s;
        r = 32'h0; ovf = 1'b0; err = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd2: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = s[31:0];
                ovf = (s > SMAX) || (s < SMIN);
            end
            3'd6: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = s[31:0];
                ovf = (s > SMAX) || (s < SMIN);
            end
            3'd7: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: err = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_id = 1'b0; m_zero = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
        m_pref = 1'b0; m_result = 32'h0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic drive(input bit v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input bit rr);
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = rr;
    endtask

    task automatic check_rsp();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            chk("rsp_result", 64'(bus.rsp_result), 64'(m_result));
            chk("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
            chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(m_ovf));
            chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        end
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", 64'(bus.grant_cnt0), 64'(m_cnt0));
        chk("grant_cnt1", 64'(bus.grant_cnt1), 64'(m_cnt1));
`else
        chk("grant_cnt0", 64'(bus.grant_cnt0), 64'd0);
        chk("grant_cnt1", 64'(bus.grant_cnt1), 64'd0);
`endif
    endtask

    // One clock: check readys against the model, advance the model, then
    // check the registered response after the edge.
    task automatic step();
        bit          free, g0, g1, ovf, err;
        logic [31:0] r;
        #1;
        free = !m_valid || bus.rsp_ready;
        g0 = 1'b0; g1 = 1'b0;
        if (free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_pref == 1'b0) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = bus.req0_valid;
                g1 = bus.req1_valid;
            end
        end
        chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
        if (g0 || g1) begin
            if (g0) ref_alu(bus.req0_op, bus.req0_a, bus.req0_b, r, ovf, err);
            else    ref_alu(bus.req1_op, bus.req1_a, bus.req1_b, r, ovf, err);
            m_valid = 1'b1; m_id = g1; m_result = r;
            m_zero = (r == 32'h0); m_ovf = ovf; m_err = err;
            m_pref = g0;
            if (g0 && m_cnt0 < 65535) m_cnt0++;
            if (g1 && m_cnt1 < 65535) m_cnt1++;
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_rsp();
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner[6];
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h0000_0001; corner[5] = 32'h8000_0001;
        if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 5)];
        else return $urandom;
    endfunction

    initial begin
        vecs[0]  = '{1'b0, 3'b100, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'b101, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'b001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b011, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        model_reset();
        #12;
        // Reset state
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("reset_rsp_zero", 64'(bus.rsp_zero), 64'd0);
        chk("reset_rsp_ovf", 64'(bus.rsp_ovf), 64'd0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("reset_cnt0", 64'(bus.grant_cnt0), 64'd0);
        chk("reset_cnt1", 64'(bus.grant_cnt1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both valid for 4 cycles -> 0,1,0,1
        drive(1'b1, 3'd0, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 3'd1, 32'h0000_1111, 32'h2222_0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contention_id", 64'(bus.rsp_id), 64'(i % 2));
        end
`ifdef ALU_ARB_STATS_EN
        chk("contention_cnt0", 64'(bus.grant_cnt0), 64'd2);
        chk("contention_cnt1", 64'(bus.grant_cnt1), 64'd2);
`endif

        // Table vectors, one client valid at a time
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].cli == 1'b0)
                drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
            else
                drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            step();
            chk("vec_valid", 64'(bus.rsp_valid), 64'd1);
            chk("vec_id", 64'(bus.rsp_id), 64'(vecs[i].cli));
            chk("vec_result", 64'(bus.rsp_result), 64'(vecs[i].res));
            chk("vec_zero", 64'(bus.rsp_zero), 64'(vecs[i].zero));
            chk("vec_ovf", 64'(bus.rsp_ovf), 64'(vecs[i].ovf));
            chk("vec_err", 64'(bus.rsp_err), 64'(vecs[i].err));
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        step();
        chk("idle_clears_valid", 64'(bus.rsp_valid), 64'd0);

        // Back-pressure: accept 1+2, then stall 3 cycles, then drain+accept
        drive(1'b1, 3'd2, 32'd1, 32'd2, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'd2, 32'd100, 32'd200, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready0", 64'(bus.req0_ready), 64'd0);
            chk("bp_result_held", 64'(bus.rsp_result), 64'd3);
            chk("bp_valid_held", 64'(bus.rsp_valid), 64'd1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("drain_accept_ready0", 64'(bus.req0_ready), 64'd1);
        step();
        chk("drain_accept_result", 64'(bus.rsp_result), 64'd300);

        // Asynchronous reset while a response is pending
        bus.rsp_ready = 1'b0;
        step();
        chk("pre_reset_valid", 64'(bus.rsp_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(bus.rsp_valid), 64'd0);
        chk("async_reset_cnt0", 64'(bus.grant_cnt0), 64'd0);
        chk("async_reset_cnt1", 64'(bus.grant_cnt1), 64'd0);
        model_reset();
        drive(1'b1, 3'd3, 32'h1234_0000, 32'h0000_5678, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_first_grant", 64'(bus.rsp_id), 64'd0);
        chk("post_reset_result", 64'(bus.rsp_result), 64'h1234_5678);

        // Randomized run against the model
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  ($urandom_range(0, 3) != 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 32-bit bitwise/arithmetic ALU datapath (AND/OR/NOR/XOR/ADD/SUB/SLT). Two independent clients issue operations over valid/ready handshakes. A round-robin arbiter grants one client per cycle to the single ALU instance, and the result lands in a one-entry registered response stage tagged with the winner's ID. The block sits between the MIPS-style issue logic and the ALU slice, so two pipes can share one datapath without duplicating it.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid, req1_valid  in  1 each  client request strobe
- req0_ready, req1_ready  out  1 each  grant/accept, combinational
- req0_op, req1_op  in  3 each  opcode: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 reserved, 110 SUB, 111 SLT
- req0_a, req0_b, req1_a, req1_b  in  32 each  operands
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  granted client (0/1)
- rsp_result  out  32  ALU result
- rsp_zero  out  1  rsp_result == 0
- rsp_ovf  out  1  signed overflow (ADD/SUB only, else 0)
- rsp_err  out  1  reserved opcode seen
- grant_cnt0, grant_cnt1  out  16 each  grant counters (only with ALU_ARB_STATS_EN)

## Operation
- Response slot free when `!rsp_valid || rsp_ready`. No grant issues while the slot is not free; both readys are 0.
- Grant rules when the slot is free:
  - Only one valid: grant that client.
  - Both valid: grant the client selected by rr_ptr.
  - Neither valid: no grant.
- After any grant, rr_ptr points to the non-granted client. With no grant, rr_ptr holds.
- reqN_ready equals grantN. Ready depends on reqN_valid, so clients must not make valid depend on ready.
- On a grant, the granted operands pass through the ALU. rsp_result, rsp_id, rsp_zero, rsp_ovf and rsp_err load, and rsp_valid sets.
- Slot free with no grant: rsp_valid clears.
- Arithmetic rules:
  - ADD/SUB: modulo 2^32. ovf = operand signs agree (B inverted for SUB) and the result sign differs.
  - SLT: signed compare, result 32'h1 or 32'h0.
  - NOR: ~(A|B).
  - Reserved 101: result 0, err 1, zero 1.
- Response is held stable while `rsp_valid && !rsp_ready`.

## Timing
- Reset values:
  - rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err = 0
  - rsp_zero = 0
  - rr_ptr = 0 (client 0 preferred)
  - counters = 0
- Latency: accept at edge T, rsp_valid high after edge T, i.e. one cycle.
- Throughput: one op per cycle when rsp_ready is held high. Drain and accept in the same cycle is required.
- A client with valid held high under contention is granted within 2 cycles of the slot being free (starvation-free).
- rst_n assertion mid-operation: the response is dropped immediately and asynchronously, with no partial state. The first grant after reset goes to client 0 if both are valid.
- Operand and op values are sampled only at the accept edge. Changes while not granted are ignored.

## Configuration
- ALU_ARB_STATS_EN defined:
  - grant_cnt0 and grant_cnt1 increment on each grant to that client.
  - Counters saturate at 16'hFFFF and reset to 0.
- ALU_ARB_STATS_EN undefined:
  - Counter logic is not compiled; grant_cnt0/grant_cnt1 are tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- Reset, then req0 NOR a=32'h0000_FFFF b=32'h00FF_0000, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=32'hFF00_0000, zero=0.
- Both valid every cycle for 4 cycles, rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence matches. With STATS_EN: cnt0=2, cnt1=2.
- req1 ADD a=32'h7FFF_FFFF b=32'h1 -> result 32'h8000_0000, ovf=1. Then SUB a=32'h5 b=32'h5 -> result 0, zero=1, ovf=0.
- rsp_ready=0 for 3 cycles with req0 valid -> req0_ready=0 throughout, response bits stable. Raise rsp_ready -> drain and new accept on the same edge.
- SLT a=32'hFFFF_FFFF b=32'h0 -> result 32'h1. Op 101 -> result 0, err=1.
- Assert rst_n low while rsp_valid=1 -> rsp_valid=0 without a clock edge. With STATS_EN: counters 0. Release with both valid -> first grant to client 0.
